// File: rtl/sram_pkg.sv
// sram_pkg: shared definitions for the true-dual-port SRAM model.
//   RD_FIRST / WR_FIRST / NO_CHANGE : same-port read-during-write behaviour
//   mask_merge()                    : bitwise write-mask merge
package sram_pkg;

  localparam int RD_FIRST  = 0;  // a write returns the word as it was before the edge
  localparam int WR_FIRST  = 1;  // a write returns the word it just committed
  localparam int NO_CHANGE = 2;  // a write leaves the read data untouched

  // Widest word the merge helper handles. Callers extend to this width and
  // truncate the result, which keeps one function usable for any DATA_W.
  localparam int MERGE_W = 1024;
  typedef logic [MERGE_W-1:0] merge_t;

  // A set mask bit keeps the stored bit; a clear mask bit takes the write bit.
  function automatic merge_t mask_merge(input merge_t old_word,
                                        input merge_t wdata,
                                        input merge_t wmsk);
    return (old_word & wmsk) | (wdata & ~wmsk);
  endfunction

endpackage

// File: rtl/sram_tdp_port.sv
// sram_tdp_port: read-data path of one SRAM port.
//   clk, rst      : clock, asynchronous active-high reset
//   i_en, i_we    : port access / write this cycle (already qualified)
//   i_old_word    : stored word at the port address before the edge
//   i_new_word    : word committed at the port address by this edge
//   o_rdata       : read data, one edge after the access (two with OUT_REG)
module sram_tdp_port
  import sram_pkg::*;
#(
  parameter int DATA_W  = 18,
  parameter int RD_MODE = RD_FIRST,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_old_word,
  input  logic [DATA_W-1:0] i_new_word,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_s1;
  logic              w_load;
  logic [DATA_W-1:0] w_s1_next;

  // Reads always load; writes load unless the port is in no-change mode.
  assign w_load    = i_en & (~i_we | (RD_MODE != NO_CHANGE));
  assign w_s1_next = (i_we && (RD_MODE == WR_FIRST)) ? i_new_word : i_old_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
    end else if (w_load) begin
      r_s1 <= w_s1_next;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] r_s2;
      // Free-running second stage: it simply follows stage 1 every edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s2 <= '0;
        end else begin
          r_s2 <= r_s1;
        end
      end
      assign o_rdata = r_s2;
    end else begin : g_no_out_reg
      assign o_rdata = r_s1;
    end
  endgenerate

endmodule

// File: rtl/sram_tdp_sync.sv
// sram_tdp_sync: single-clock true-dual-port SRAM with per-bit write masks.
//   clk, rst                      : clock, asynchronous active-high reset
//   i_cen_a/b, i_wen_a/b          : active-low port enable / write enable
//   i_addr_a/b                    : word address
//   i_wmsk_a/b                    : per-bit mask, 1 keeps the stored bit
//   i_wdata_a/b                   : write data
//   o_rdata_a/b                   : read data
//   o_coll                        : one-cycle same-address collision pulse
// Contents come from INIT at time zero; reset only clears the output side.
module sram_tdp_sync
  import sram_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 18,
  parameter int RD_MODE = RD_FIRST,
  parameter int OUT_REG = 0,
  parameter logic [(2**ADDR_W)*DATA_W-1:0] INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cen_a,
  input  logic              i_wen_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [DATA_W-1:0] i_wmsk_a,
  input  logic [DATA_W-1:0] i_wdata_a,
  input  logic              i_cen_b,
  input  logic              i_wen_b,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [DATA_W-1:0] i_wmsk_b,
  input  logic [DATA_W-1:0] i_wdata_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic              o_coll
);

  localparam int DEPTH = 2**ADDR_W;

  // Packed word array so INIT maps directly: word i = INIT[i*DATA_W +: DATA_W].
  logic [DEPTH-1:0][DATA_W-1:0] r_mem = INIT;
  logic                         r_coll;

  logic              w_en_a, w_we_a, w_en_b, w_we_b, w_same;
  logic [DATA_W-1:0] w_old_a, w_old_b;
  logic [DATA_W-1:0] w_new_b, w_base_a, w_new_a, w_commit_b;

  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_word,
                                                input logic [DATA_W-1:0] wdata,
                                                input logic [DATA_W-1:0] wmsk);
    return DATA_W'(mask_merge(merge_t'(old_word), merge_t'(wdata), merge_t'(wmsk)));
  endfunction

  // Reset blocks every access, so all downstream effects key off these.
  assign w_en_a = ~i_cen_a & ~rst;
  assign w_en_b = ~i_cen_b & ~rst;
  assign w_we_a = w_en_a & ~i_wen_a;
  assign w_we_b = w_en_b & ~i_wen_b;
  assign w_same = (i_addr_a == i_addr_b);

  assign w_old_a = r_mem[i_addr_a];
  assign w_old_b = r_mem[i_addr_b];

  // On a shared write address B is merged first and A is merged on top, so
  // A owns every bit it unmasks and B only reaches bits A left masked.
  assign w_new_b    = f_merge(w_old_b, i_wdata_b, i_wmsk_b);
  assign w_base_a   = (w_we_b && w_same) ? w_new_b : w_old_a;
  assign w_new_a    = f_merge(w_base_a, i_wdata_a, i_wmsk_a);
  assign w_commit_b = (w_we_a && w_same) ? w_new_a : w_new_b;

  // Port A's assignment comes last so it wins when both target one word.
  always_ff @(posedge clk) begin
    if (w_we_b) begin
      r_mem[i_addr_b] <= w_new_b;
    end
    if (w_we_a) begin
      r_mem[i_addr_a] <= w_new_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_coll <= 1'b0;
    end else begin
      r_coll <= w_en_a & w_en_b & w_same & (w_we_a | w_we_b);
    end
  end

  assign o_coll = r_coll;

  sram_tdp_port #(
    .DATA_W (DATA_W),
    .RD_MODE(RD_MODE),
    .OUT_REG(OUT_REG)
  ) u_port_a (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_en_a),
    .i_we      (w_we_a),
    .i_old_word(w_old_a),
    .i_new_word(w_new_a),
    .o_rdata   (o_rdata_a)
  );

  sram_tdp_port #(
    .DATA_W (DATA_W),
    .RD_MODE(RD_MODE),
    .OUT_REG(OUT_REG)
  ) u_port_b (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_en_b),
    .i_we      (w_we_b),
    .i_old_word(w_old_b),
    .i_new_word(w_commit_b),
    .o_rdata   (o_rdata_b)
  );

endmodule

// File: tb/tb_sram_tdp_sync.sv
// Testbench for sram_tdp_sync. Instances 0..2 cover the three read modes,
// instance 3 adds the output register and a non-zero INIT word; all four
// share one stimulus. A separate 16x8 instance covers the small geometry.
module tb_sram_tdp_sync;

  localparam int AW    = 10;
  localparam int DW    = 18;
  localparam int DEPTH = 1024;
  localparam logic [DEPTH*DW-1:0] R_INIT = {{((DEPTH-2)*DW){1'b0}}, 18'h0002A, 18'h00000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cen_a, wen_a, cen_b, wen_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wmsk_a, wdata_a, wmsk_b, wdata_b;
  logic [DW-1:0] rda [4];
  logic [DW-1:0] rdb [4];
  logic          col [4];

  logic       s_cen_a, s_wen_a, s_cen_b, s_wen_b;
  logic [3:0] s_addr_a, s_addr_b;
  logic [7:0] s_wmsk_a, s_wdata_a, s_wmsk_b, s_wdata_b, s_rda, s_rdb;
  logic       s_coll;

  for (genvar gi = 0; gi < 3; gi++) begin : g_mode
    sram_tdp_sync #(.ADDR_W(AW), .DATA_W(DW), .RD_MODE(gi), .OUT_REG(0)) u_dut (
      .clk(clk), .rst(rst),
      .i_cen_a(cen_a), .i_wen_a(wen_a), .i_addr_a(addr_a), .i_wmsk_a(wmsk_a), .i_wdata_a(wdata_a),
      .i_cen_b(cen_b), .i_wen_b(wen_b), .i_addr_b(addr_b), .i_wmsk_b(wmsk_b), .i_wdata_b(wdata_b),
      .o_rdata_a(rda[gi]), .o_rdata_b(rdb[gi]), .o_coll(col[gi])
    );
  end

  sram_tdp_sync #(.ADDR_W(AW), .DATA_W(DW), .RD_MODE(0), .OUT_REG(1), .INIT(R_INIT)) u_reg (
    .clk(clk), .rst(rst),
    .i_cen_a(cen_a), .i_wen_a(wen_a), .i_addr_a(addr_a), .i_wmsk_a(wmsk_a), .i_wdata_a(wdata_a),
    .i_cen_b(cen_b), .i_wen_b(wen_b), .i_addr_b(addr_b), .i_wmsk_b(wmsk_b), .i_wdata_b(wdata_b),
    .o_rdata_a(rda[3]), .o_rdata_b(rdb[3]), .o_coll(col[3])
  );

  sram_tdp_sync #(.ADDR_W(4), .DATA_W(8)) u_small (
    .clk(clk), .rst(rst),
    .i_cen_a(s_cen_a), .i_wen_a(s_wen_a), .i_addr_a(s_addr_a), .i_wmsk_a(s_wmsk_a), .i_wdata_a(s_wdata_a),
    .i_cen_b(s_cen_b), .i_wen_b(s_wen_b), .i_addr_b(s_addr_b), .i_wmsk_b(s_wmsk_b), .i_wdata_b(s_wdata_b),
    .o_rdata_a(s_rda), .o_rdata_b(s_rdb), .o_coll(s_coll)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] mem_m [DEPTH];   // contents seen by the INIT-zero instances
  logic [DW-1:0] mem_r [DEPTH];   // contents seen by the output-register instance
  logic [DW-1:0] exp_a [4];
  logic [DW-1:0] exp_b [4];
  logic [DW-1:0] s1_a, s1_b;      // first output stage of instance 3
  logic          exp_c;
  int            n_pass = 0;
  int            n_total = 0;
  int            n_txn = 0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_word,
                                          input logic [DW-1:0] d,
                                          input logic [DW-1:0] m);
    return (old_word & m) | (d & ~m);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      exp_a[i] = '0;
      exp_b[i] = '0;
    end
    s1_a  = '0;
    s1_b  = '0;
    exp_c = 1'b0;
  endtask

  // Effect of one rising edge, from the rules for accesses, modes and writes.
  task automatic model_edge();
    logic          ea, eb, wa, wb;
    logic [DW-1:0] oa_m, ob_m, oa_r, ob_r;
    if (rst) begin
      clear_model();
      return;
    end
    ea = !cen_a;
    eb = !cen_b;
    wa = ea && !wen_a;
    wb = eb && !wen_b;
    oa_m = mem_m[addr_a];
    ob_m = mem_m[addr_b];
    oa_r = mem_r[addr_a];
    ob_r = mem_r[addr_b];
    if (wb) begin
      mem_m[addr_b] = merge(mem_m[addr_b], wdata_b, wmsk_b);
      mem_r[addr_b] = merge(mem_r[addr_b], wdata_b, wmsk_b);
    end
    if (wa) begin
      mem_m[addr_a] = merge(mem_m[addr_a], wdata_a, wmsk_a);
      mem_r[addr_a] = merge(mem_r[addr_a], wdata_a, wmsk_a);
    end
    for (int m = 0; m < 3; m++) begin
      if (ea) begin
        if (!wa || m == 0) exp_a[m] = oa_m;
        else if (m == 1)   exp_a[m] = mem_m[addr_a];
      end
      if (eb) begin
        if (!wb || m == 0) exp_b[m] = ob_m;
        else if (m == 1)   exp_b[m] = mem_m[addr_b];
      end
    end
    exp_a[3] = s1_a;
    exp_b[3] = s1_b;
    if (ea) s1_a = oa_r;
    if (eb) s1_b = ob_r;
    exp_c = ea && eb && (addr_a == addr_b) && (wa || wb);
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %05h, expected %05h", name, act, exp);
  endtask

  task automatic compare_model();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("model rdata_a[%0d]", i), rda[i], exp_a[i]);
      check($sformatf("model rdata_b[%0d]", i), rdb[i], exp_b[i]);
      check($sformatf("model coll[%0d]", i), DW'(col[i]), DW'(exp_c));
    end
  endtask

  task automatic idle();
    cen_a = 1'b1; wen_a = 1'b1; addr_a = '0; wmsk_a = '0; wdata_a = '0;
    cen_b = 1'b1; wen_b = 1'b1; addr_b = '0; wmsk_b = '0; wdata_b = '0;
  endtask

  // Entered at a falling edge with inputs set; leaves at the next falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    n_txn++;
    $display("txn %0d rst=%b A[c%b w%b @%0d m=%05h d=%05h] B[c%b w%b @%0d m=%05h d=%05h] -> rdA=%05h rdB=%05h coll=%b",
             n_txn, rst, cen_a, wen_a, addr_a, wmsk_a, wdata_a, cen_b, wen_b, addr_b, wmsk_b, wdata_b,
             rda[0], rdb[0], col[0]);
  endtask

  // ---------------- directed vectors for instance 0 (read-first) ----------------
  typedef struct packed {
    logic cen_a; logic wen_a; logic [AW-1:0] addr_a; logic [DW-1:0] wmsk_a; logic [DW-1:0] wdata_a;
    logic cen_b; logic wen_b; logic [AW-1:0] addr_b; logic [DW-1:0] wmsk_b; logic [DW-1:0] wdata_b;
    logic [DW-1:0] exp_a; logic [DW-1:0] exp_b; logic exp_c;
  } vec_t;

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 10'd5, 18'h00000, 18'h3FFFF, 1'b1, 1'b1, 10'd0, 18'h00000, 18'h00000, 18'h00000, 18'h00000, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 10'd0, 18'h00000, 18'h00000, 1'b0, 1'b1, 10'd5, 18'h00000, 18'h00000, 18'h00000, 18'h3FFFF, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 10'd7, 18'h3FF00, 18'h3FFFF, 1'b1, 1'b1, 10'd0, 18'h00000, 18'h00000, 18'h00000, 18'h3FFFF, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 10'd7, 18'h00000, 18'h00000, 1'b1, 1'b1, 10'd0, 18'h00000, 18'h00000, 18'h000FF, 18'h3FFFF, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 10'd9, 18'h00000, 18'h0AAAA, 1'b0, 1'b0, 10'd9, 18'h00000, 18'h15555, 18'h00000, 18'h00000, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 10'd0, 18'h00000, 18'h00000, 1'b1, 1'b1, 10'd0, 18'h00000, 18'h00000, 18'h00000, 18'h00000, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 10'd9, 18'h00000, 18'h00000, 1'b0, 1'b1, 10'd9, 18'h00000, 18'h00000, 18'h0AAAA, 18'h0AAAA, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 10'd9, 18'h3FFF0, 18'h00005, 1'b0, 1'b0, 10'd9, 18'h3FF00, 18'h000FF, 18'h0AAAA, 18'h0AAAA, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 10'd9, 18'h00000, 18'h00000, 1'b0, 1'b1, 10'd9, 18'h00000, 18'h00000, 18'h0AAF5, 18'h0AAF5, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 10'd8, 18'h00000, 18'h00000, 1'b0, 1'b0, 10'd8, 18'h00000, 18'h12345, 18'h00000, 18'h00000, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 10'd8, 18'h00000, 18'h00000, 1'b1, 1'b1, 10'd0, 18'h00000, 18'h00000, 18'h12345, 18'h00000, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 10'd3, 18'h00000, 18'h00011, 1'b1, 1'b1, 10'd0, 18'h00000, 18'h00000, 18'h00000, 18'h00000, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 10'd3, 18'h00000, 18'h00022, 1'b1, 1'b1, 10'd0, 18'h00000, 18'h00000, 18'h00011, 18'h00000, 1'b0};

    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = '0;
      mem_r[i] = '0;
    end
    mem_r[1] = 18'h0002A;
    clear_model();

    rst = 1'b1;
    idle();
    s_cen_a = 1'b1; s_wen_a = 1'b1; s_addr_a = '0; s_wmsk_a = '0; s_wdata_a = '0;
    s_cen_b = 1'b1; s_wen_b = 1'b1; s_addr_b = '0; s_wmsk_b = '0; s_wdata_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset rdata_a[%0d]", i), rda[i], '0);
      check($sformatf("reset rdata_b[%0d]", i), rdb[i], '0);
      check($sformatf("reset coll[%0d]", i), DW'(col[i]), '0);
    end
    rst = 1'b0;

    // Table: write/read, mask merge, arbitration, cross-port read-old, modes.
    for (int i = 0; i < 13; i++) begin
      {cen_a, wen_a, addr_a, wmsk_a, wdata_a, cen_b, wen_b, addr_b, wmsk_b, wdata_b} =
        {vecs[i].cen_a, vecs[i].wen_a, vecs[i].addr_a, vecs[i].wmsk_a, vecs[i].wdata_a,
         vecs[i].cen_b, vecs[i].wen_b, vecs[i].addr_b, vecs[i].wmsk_b, vecs[i].wdata_b};
      step();
      check($sformatf("vec%0d rdata_a", i), rda[0], vecs[i].exp_a);
      check($sformatf("vec%0d rdata_b", i), rdb[0], vecs[i].exp_b);
      check($sformatf("vec%0d coll", i), DW'(col[0]), DW'(vecs[i].exp_c));
    end
    // Last vector overwrote addr 3 (0x11) with 0x22 on port A.
    check("write-first same-port", rda[1], 18'h00022);
    check("no-change same-port", rda[2], 18'h12345);
    idle();
    step();
    check("coll single cycle", DW'(col[0]), '0);
    compare_model();

    // Asynchronous reset clears outputs at once and leaves memory intact.
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async rst rdata_a[%0d]", i), rda[i], '0);
      check($sformatf("async rst rdata_b[%0d]", i), rdb[i], '0);
    end
    clear_model();
    #1 rst = 1'b0;
    cen_a = 1'b0; wen_a = 1'b1; addr_a = 10'd9;
    step();
    check("contents survive rst", rda[0], 18'h0AAF5);
    compare_model();

    // Output register: INIT word 1 appears one extra edge later.
    cen_a = 1'b0; wen_a = 1'b1; addr_a = 10'd1;
    step();
    compare_model();
    idle();
    step();
    check("outreg k+1", rda[3], 18'h0002A);
    compare_model();

    // Reset between k and k+1 discards the word in flight.
    cen_a = 1'b0; wen_a = 1'b1; addr_a = 10'd9;
    step();
    check("outreg before rst", rda[3], 18'h0002A);
    idle();
    rst = 1'b1;
    #1;
    check("outreg rst now", rda[3], '0);
    clear_model();
    #1 rst = 1'b0;
    step();
    check("outreg discarded k+1", rda[3], '0);
    step();
    check("outreg stays 0", rda[3], '0);
    compare_model();

    // Random traffic against the model.
    for (int t = 0; t < 1500; t++) begin
      rst    = ($urandom_range(0, 63) == 0);
      cen_a  = ($urandom_range(0, 3) == 0);
      wen_a  = $urandom_range(0, 1) == 1;
      addr_a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH-1)) : AW'($urandom_range(0, 15));
      wmsk_a = DW'($urandom);
      wdata_a = DW'($urandom);
      cen_b  = ($urandom_range(0, 3) == 0);
      wen_b  = $urandom_range(0, 1) == 1;
      addr_b = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH-1)) : AW'($urandom_range(0, 15));
      wmsk_b = DW'($urandom);
      wdata_b = DW'($urandom);
      // Dual writes to one word are covered by the directed vectors.
      if (!cen_a && !wen_a && !cen_b && !wen_b && addr_a == addr_b) wen_b = 1'b1;
      step();
      compare_model();
    end
    rst = 1'b0;
    idle();

    // 16x8 geometry: the extreme addresses must not alias.
    s_cen_a = 1'b0; s_wen_a = 1'b0; s_addr_a = 4'd0;  s_wmsk_a = 8'h00; s_wdata_a = 8'hA5;
    s_cen_b = 1'b0; s_wen_b = 1'b0; s_addr_b = 4'd15; s_wmsk_b = 8'h00; s_wdata_b = 8'h3C;
    step();
    check("small coll diff addr", DW'(s_coll), '0);
    s_wen_a = 1'b1; s_addr_a = 4'd15;
    s_wen_b = 1'b1; s_addr_b = 4'd0;
    step();
    check("small read 15", DW'(s_rda), DW'(8'h3C));
    check("small read 0", DW'(s_rdb), DW'(8'hA5));
    s_wen_a = 1'b0; s_addr_a = 4'd15; s_wmsk_a = 8'hF0; s_wdata_a = 8'h0F;
    step();
    s_wen_a = 1'b1; s_addr_a = 4'd0;
    s_addr_b = 4'd15;
    step();
    check("small addr 0 kept", DW'(s_rda), DW'(8'hA5));
    check("small addr 15 merged", DW'(s_rdb), DW'(8'h3F));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_tdp_sync.md
# sram_tdp_sync

Parametrised single-clock true-dual-port SRAM behavioural model with per-bit write masks, a selectable same-port read-during-write mode, an optional output register stage and address-collision reporting. It is the generalised successor of the fixed 1024x18 dual-port macro model. It sits under the memory-inference mapping flow as the simulation and synthesis target for block RAM of any width and depth.

## Interface
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words
- DATA_W, 18, word and mask width
- RD_MODE, 0, same-port read-during-write: 0 read-first, 1 write-first, 2 no-change
- OUT_REG, 0, 1 adds one output register stage on both ports
- INIT, all zero, DEPTH*DATA_W bits; word i = INIT[i*DATA_W +: DATA_W]
- clk  in  1  single clock for both ports, rising edge (clkbuf_sink)
- rst  in  1  asynchronous, active-high reset
- cen_a / cen_b  in  1  port enable, active low
- wen_a / wen_b  in  1  write enable, active low, qualified by cen
- addr_a / addr_b  in  ADDR_W  word address
- wmsk_a / wmsk_b  in  DATA_W  per-bit mask; 1 = keep stored bit, 0 = write wdata bit
- wdata_a / wdata_b  in  DATA_W  write data
- rdata_a / rdata_b  out  DATA_W  read data
- coll  out  1  one-cycle pulse: same-address collision detected

## Operation
- Access on port p at edge k when cen_p=0 and rst=0; write when additionally wen_p=0.
- Write: new word = (old & wmsk) | (wdata & ~wmsk), committed at edge k.
- Read (wen_p=1): rdata_p = stored word at addr_p before edge k.
- Same-port write, RD_MODE 0: rdata_p = old word; 1: rdata_p = merged new word; 2: rdata_p holds.
- Cross-port read of address written by the other port at the same edge: always returns old word.
- Write-write same address: port A wins on every bit where wmsk_a=0; port B's bits apply only where wmsk_a=1 and wmsk_b=0.
- cen_p=1: rdata_p holds its last value; no memory change.
- coll: asserted for the cycle after edge k when both ports enabled, addr_a==addr_b, and at least one port writes.
- Memory array is initialised from INIT at time zero only; rst never alters contents.

## Timing
- OUT_REG=0: rdata_p updates at edge k (latency 1 edge, sampled downstream at k+1).
- OUT_REG=1: rdata_p updates at edge k+1; stage-1 register captures regardless of downstream, holds when cen_p=1 at k.
- rst asserted: rdata_a, rdata_b, stage-1 registers and coll go to 0 immediately; all writes and reads blocked while rst=1.
- Reset mid-pipeline: data in flight in stage 1 is discarded; first post-reset output reflects first post-reset access.
- Back-to-back accesses at full rate on both ports; no stalls, no handshake.
- Address wrap: none; every address in 0..DEPTH-1 valid, no out-of-range case exists.

## Structure
- Package sram_pkg: RD_MODE constants (RD_FIRST=0, WR_FIRST=1, NO_CHANGE=2), mask-merge function.
- Sub-module sram_tdp_port: per-port read-mode selection and optional output stage; instantiated twice. Array, write arbitration and coll live in top.

## Test plan
- Defaults, port A write addr 5 data 0x3FFFF mask 0, then read addr 5 on port B -> rdata_b = 0x3FFFF one edge later.
- Addr 7 holds 0x00000; write 0x3FFFF with mask 0x3FF00 -> subsequent read 0x000FF.
- RD_MODE 0/1/2, addr 3 holds 0x11, port A write 0x22 -> rdata_a = 0x11 / 0x22 / previous value.
- Both ports write addr 9 same edge, A 0x0AAAA mask 0, B 0x15555 -> stored 0x0AAAA, coll=1 for exactly one cycle.
- OUT_REG=1, read addr 1 (INIT word 0x2A) -> rdata appears at k+1; assert rst between k and k+1 -> rdata 0, stays 0 after release.
- ADDR_W=4, DATA_W=8: write/read addresses 0 and 15 -> correct data, no aliasing.
